// File: rtl/seq_array_mult_if.sv
// Operand/result handshake bundle for the sequential shift-add multiplier.
// The slave modport is the multiplier's view; the master modport is the
// operand source / result consumer view.
interface seq_array_mult_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic                   in_signed;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     out_product;
  logic                   busy;

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, out_product, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/seq_array_mult.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or
// two's-complement per operation. Operands are reduced to magnitudes on
// accept, multiplied one multiplier bit per clock, and the sign is applied
// in a single fix-up cycle before the result is presented.
module seq_array_mult #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  seq_array_mult_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]   PROD_ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     OPD_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               state_r;
  state_t               next_state_s;

  logic [WIDTH-1:0]     a_mag_r;
  logic [WIDTH-1:0]     b_mag_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 neg_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic                 in_ready_s;
  logic                 out_valid_s;
  logic                 busy_s;

  logic                 mode_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   acc_next_s;

  // Unsigned magnitude of an operand; -2^(WIDTH-1) maps onto itself, which
  // is exactly 2^(WIDTH-1) when read back as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                 input logic             is_signed);
    logic [WIDTH-1:0] result;
    if (is_signed && value[WIDTH-1]) begin
      result = ~value + OPD_ONE;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Sign handling is only live when the build enables it.
  assign mode_s = bus.in_signed & SIGNED_EN;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_LAST) begin
          next_state_s = ST_FIX;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_FIX: begin
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Handshake/status outputs decoded from the upcoming state so they can be
  // registered and still line up with the state they describe.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (next_state_s)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b0;
      end
      ST_BUSY: begin
        busy_s = 1'b1;
      end
      ST_FIX: begin
        busy_s = 1'b1;
      end
      ST_DONE: begin
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Output flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  // One shift-add step: conditionally add |A| into the upper half, then
  // shift {carry, acc} right so the carry lands in the top bit.
  always_comb begin
    sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    if (b_mag_r[0]) begin
      sum_s = sum_s + {1'b0, a_mag_r};
    end else begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
  end

  // Datapath: operand capture, iteration, and sign fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_r   <= '0;
      b_mag_r   <= '0;
      acc_r     <= '0;
      product_r <= '0;
      neg_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_mag_r <= magnitude(bus.in_a, mode_s);
            b_mag_r <= magnitude(bus.in_b, mode_s);
            neg_r   <= mode_s & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
            acc_r   <= '0;
            cnt_r   <= '0;
          end
        end
        ST_BUSY: begin
          acc_r   <= acc_next_s;
          b_mag_r <= {1'b0, b_mag_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + CNT_ONE;
        end
        ST_FIX: begin
          // Negating zero yields zero, so a zero product never turns negative.
          product_r <= neg_r ? (~acc_r + PROD_ONE) : acc_r;
        end
        ST_DONE: begin
          product_r <= product_r;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.busy        = busy_r;
  assign bus.out_product = product_r;

endmodule

// File: tb/tb_seq_array_mult.sv
// Self-checking bench for seq_array_mult: three instances (8-bit signed,
// 4-bit signed, 4-bit unsigned-only) checked against an integer reference.
module tb_seq_array_mult;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  seq_array_mult_if #(.WIDTH(8)) bus8 ();
  seq_array_mult_if #(.WIDTH(4)) bus4 ();
  seq_array_mult_if #(.WIDTH(4)) bus4u ();

  seq_array_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seq_array_mult #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seq_array_mult #(.WIDTH(4), .SIGNED_EN(1'b0)) dut4u (.clk(clk), .rst(rst), .bus(bus4u));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
  function automatic logic [31:0] ref_mult(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input bit s);
    longint av;
    longint bv;
    longint p;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 32'(p & ((longint'(1) << (2 * w)) - 64'sd1));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One operation on both 4-bit instances in lockstep.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output logic [7:0] p, output logic [7:0] pu,
                     output int lat, output int hs_err);
    hs_err = 0;
    if (bus4.in_ready !== 1'b1 || bus4u.in_ready !== 1'b1) hs_err++;
    bus4.in_a = a;  bus4.in_b = b;  bus4.in_signed = s;  bus4.in_valid = 1'b1;
    bus4u.in_a = a; bus4u.in_b = b; bus4u.in_signed = s; bus4u.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0; bus4u.in_valid = 1'b0;
    bus4.in_a = ~a; bus4.in_b = ~b; bus4u.in_a = ~a; bus4u.in_b = ~b;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 40) begin
      if (bus4.in_ready !== 1'b0 || bus4.busy !== 1'b1) hs_err++;
      @(posedge clk); #1;
      lat++;
    end
    p  = bus4.out_product;
    pu = bus4u.out_product;
    if (bus4u.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) hs_err++;
    bus4.out_ready = 1'b1; bus4u.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0; bus4u.out_ready = 1'b0;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.busy !== 1'b0) hs_err++;
  endtask

  // One operation on the 8-bit instance with optional result stall, an
  // ignored in_valid pulse during the stall, and out_ready noise while busy.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input int stall, input bit poke, input bit noise,
                     output logic [15:0] p, output int lat, output int hs_err);
    hs_err = 0;
    if (bus8.in_ready !== 1'b1) hs_err++;
    bus8.in_a = a; bus8.in_b = b; bus8.in_signed = s; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom); bus8.in_signed = 1'($urandom);
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 60) begin
      if (bus8.in_ready !== 1'b0 || bus8.busy !== 1'b1) hs_err++;
      bus8.out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    bus8.out_ready = 1'b0;
    p = bus8.out_product;
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 5) begin
        bus8.in_valid = 1'b1;
        bus8.in_a = 8'($urandom); bus8.in_b = 8'($urandom);
      end else begin
        bus8.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (bus8.out_valid !== 1'b1 || bus8.out_product !== p ||
          bus8.in_ready !== 1'b0 || bus8.busy !== 1'b1) hs_err++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) hs_err++;
  endtask

  task automatic test_reset();
    check("rst_in_ready8", 32'(bus8.in_ready), 32'd1);
    check("rst_out_valid8", 32'(bus8.out_valid), 32'd0);
    check("rst_busy8", 32'(bus8.busy), 32'd0);
    check("rst_product8", 32'(bus8.out_product), 32'd0);
    check("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
    check("rst_product4", 32'(bus4.out_product), 32'd0);
  endtask

  task automatic test_unsigned_w4();
    logic [7:0] p;
    logic [7:0] pu;
    int lat;
    int hs;
    op4(4'd13, 4'd11, 1'b0, p, pu, lat, hs);
    check("u4_product", 32'(p), 32'h8F);
    check("u4_product_se0", 32'(pu), 32'h8F);
    check("u4_latency", 32'(lat), 32'd5);
    check("u4_handshake", 32'(hs), 32'd0);
  endtask

  task automatic test_signed_w4();
    logic [3:0] ta [4] = '{4'hD, 4'h8, 4'h8, 4'h0};
    logic [3:0] tb [4] = '{4'h5, 4'h8, 4'h7, 4'hB};
    logic [7:0] tp [4] = '{8'hF1, 8'h40, 8'hC8, 8'h00};
    logic [7:0] tu [4] = '{8'h41, 8'h40, 8'h38, 8'h00};
    logic [7:0] p;
    logic [7:0] pu;
    int lat;
    int hs;
    for (int i = 0; i < 4; i++) begin
      op4(ta[i], tb[i], 1'b1, p, pu, lat, hs);
      check($sformatf("s4_product_%0d", i), 32'(p), 32'(tp[i]));
      check($sformatf("s4_ignored_sign_%0d", i), 32'(pu), 32'(tu[i]));
      check($sformatf("s4_handshake_%0d", i), 32'(hs), 32'd0);
    end
  endtask

  task automatic test_stall_w8();
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int lat;
    int hs;
    a = 8'($urandom);
    b = 8'($urandom);
    op8(a, b, 1'b1, 20, 1'b1, 1'b0, p, lat, hs);
    check("stall_product", 32'(p), ref_mult(8, 16'(a), 16'(b), 1'b1));
    check("stall_latency", 32'(lat), 32'd9);
    check("stall_hold", 32'(hs), 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic       qs [$];
    logic [7:0] ea;
    logic [7:0] eb;
    logic       es;
    int last_t;
    int n_res;
    last_t = -1;
    n_res  = 0;
    bus8.out_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      bus8.in_valid  = (cyc < 80) ? 1'b1 : 1'b0;
      bus8.in_a      = 8'($urandom);
      bus8.in_b      = 8'($urandom);
      bus8.in_signed = 1'($urandom);
      if (bus8.in_ready === 1'b1 && bus8.in_valid === 1'b1) begin
        qa.push_back(bus8.in_a); qb.push_back(bus8.in_b); qs.push_back(bus8.in_signed);
      end
      @(posedge clk); #1;
      if (bus8.out_valid === 1'b1) begin
        if (qa.size() == 0) begin
          check("b2b_unexpected_result", 32'd1, 32'd0);
        end else begin
          ea = qa.pop_front(); eb = qb.pop_front(); es = qs.pop_front();
          check("b2b_product", 32'(bus8.out_product), ref_mult(8, 16'(ea), 16'(eb), es));
        end
        if (last_t >= 0) check("b2b_interval", 32'(cyc - last_t), 32'd11);
        last_t = cyc;
        n_res++;
      end
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    check("b2b_lost", 32'(qa.size()), 32'd0);
    check("b2b_count", 32'(n_res >= 7), 32'd1);
  endtask

  task automatic test_reset_mid_busy();
    logic [15:0] p;
    int lat;
    int hs;
    int seen;
    bus8.in_a = 8'hA5; bus8.in_b = 8'h3C; bus8.in_signed = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("mid_rst_busy", 32'(bus8.busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("mid_rst_product", 32'(bus8.out_product), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    op8(8'hFF, 8'hFF, 1'b0, 0, 1'b0, 1'b0, p, lat, hs);
    check("post_rst_product", 32'(p), 32'hFE01);
    check("post_rst_latency", 32'(lat), 32'd9);
  endtask

  task automatic test_random_sweep();
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
    int lat;
    int hs;
    for (int n = 0; n < 2000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      if (n == 0) begin a = 8'h80; b = 8'h80; s = 1'b1; end
      if (n == 1) begin a = 8'hFF; b = 8'hFF; s = 1'b0; end
      op8(a, b, s, $urandom_range(0, 3), 1'b0, 1'b1, p, lat, hs);
      check($sformatf("sweep_product a=%0h b=%0h s=%0d", a, b, s), 32'(p),
            ref_mult(8, 16'(a), 16'(b), s));
      check("sweep_latency", 32'(lat), 32'd9);
      check("sweep_handshake", 32'(hs), 32'd0);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus8.in_valid = 1'b0;  bus8.in_a = '0;  bus8.in_b = '0;  bus8.in_signed = 1'b0;  bus8.out_ready = 1'b0;
    bus4.in_valid = 1'b0;  bus4.in_a = '0;  bus4.in_b = '0;  bus4.in_signed = 1'b0;  bus4.out_ready = 1'b0;
    bus4u.in_valid = 1'b0; bus4u.in_a = '0; bus4u.in_b = '0; bus4u.in_signed = 1'b0; bus4u.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_unsigned_w4();
    test_signed_w4();
    test_stall_w8();
    test_back_to_back();
    test_reset_mid_busy();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
